// File: rtl/ca_pkg.sv
// Shared types, rule constants and the neighbour-count helper for the
// Life-like cellular-automaton engine.
package ca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } modeState_t;

  localparam int NBR_W = 4;

  localparam logic [8:0] LIFE_BIRTH     = 9'h008;
  localparam logic [8:0] LIFE_SURVIVE   = 9'h00C;
  localparam logic [8:0] HIGHLIFE_BIRTH = 9'h048;

  // Live-neighbour count; result is always in 0..8.
  function automatic logic [NBR_W-1:0] popCount8(input logic [7:0] bits);
    logic [NBR_W-1:0] cnt;
    cnt = {NBR_W{1'b0}};
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {{(NBR_W-1){1'b0}}, bits[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ca_cell.sv
// Next-state logic for one cell: counts live neighbours and applies the
// birth/survive masks. Purely combinational.
module ca_cell
  import ca_pkg::*;
(
  input  logic [7:0] nbrs,
  input  logic       cellState,
  input  logic [8:0] birthMask,
  input  logic [8:0] surviveMask,
  output logic       nextState
);

  logic [NBR_W-1:0] liveCount_s;

  // Rule lookup indexed by the neighbour count.
  always_comb begin
    liveCount_s = popCount8(nbrs);
    if (cellState) begin
      nextState = surviveMask[liveCount_s];
    end else begin
      nextState = birthMask[liveCount_s];
    end
  end

endmodule

// File: rtl/life_like_ca.sv
// ROWS x COLS Life-like automaton: grid register, mode FSM, generation
// divider and status flags, with per-cell rule logic in ca_cell.
module life_like_ca
  import ca_pkg::*;
#(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int STEP_DIV = 1,
  parameter int GEN_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       run,
  input  logic                       step,
  input  logic                       wrap,
  input  logic [8:0]                 birthMask,
  input  logic [8:0]                 surviveMask,
  input  logic [ROWS-1:0][COLS-1:0]  userInput,
  output logic [ROWS-1:0][COLS-1:0]  cellStatus,
  output logic [GEN_W-1:0]           generation,
  output logic                       extinct,
  output logic                       stable
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic [ROWS-1:0][COLS-1:0] grid_r;
  logic [ROWS-1:0][COLS-1:0] nextGrid_s;
  logic [GEN_W-1:0]          gen_r;
  logic                      extinct_r;
  logic                      stable_r;
  logic                      stepPrev_r;
  logic                      stepRise_s;
  modeState_t                state_r;
  modeState_t                state_s;
  logic [DIV_W-1:0]          div_r;
  logic [DIV_W-1:0]          div_s;
  logic                      advance_s;

  // Out-of-grid neighbours are masked to zero unless wrap is set.
  for (genvar r = 0; r < ROWS; r++) begin : gRow
    for (genvar c = 0; c < COLS; c++) begin : gCol
      localparam int RU = (r == 0) ? ROWS - 1 : r - 1;
      localparam int RD = (r == ROWS - 1) ? 0 : r + 1;
      localparam int CL = (c == 0) ? COLS - 1 : c - 1;
      localparam int CR = (c == COLS - 1) ? 0 : c + 1;
      localparam logic TOP_EDGE   = (r == 0);
      localparam logic BOT_EDGE   = (r == ROWS - 1);
      localparam logic LEFT_EDGE  = (c == 0);
      localparam logic RIGHT_EDGE = (c == COLS - 1);

      logic       upOk_s;
      logic       dnOk_s;
      logic       lfOk_s;
      logic       rtOk_s;
      logic [7:0] nbrs_s;

      assign upOk_s = wrap | ~TOP_EDGE;
      assign dnOk_s = wrap | ~BOT_EDGE;
      assign lfOk_s = wrap | ~LEFT_EDGE;
      assign rtOk_s = wrap | ~RIGHT_EDGE;

      assign nbrs_s = {
        grid_r[RD][CR] & dnOk_s & rtOk_s,
        grid_r[RD][c]  & dnOk_s,
        grid_r[RD][CL] & dnOk_s & lfOk_s,
        grid_r[r][CR]  & rtOk_s,
        grid_r[r][CL]  & lfOk_s,
        grid_r[RU][CR] & upOk_s & rtOk_s,
        grid_r[RU][c]  & upOk_s,
        grid_r[RU][CL] & upOk_s & lfOk_s
      };

      ca_cell uCell (
        .nbrs        (nbrs_s),
        .cellState   (grid_r[r][c]),
        .birthMask   (birthMask),
        .surviveMask (surviveMask),
        .nextState   (nextGrid_s[r][c])
      );
    end
  end

  assign stepRise_s = step & ~stepPrev_r;

  // Mode FSM next state, divider and advance strobe.
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    advance_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (run) begin
          // Counting starts on the entry edge so the first generation
          // lands on the STEP_DIV-th edge with run high.
          state_s = RUN;
          if (div_r == DIV_LAST) begin
            advance_s = 1'b1;
            div_s     = {DIV_W{1'b0}};
          end else begin
            div_s = div_r + DIV_W'(1);
          end
        end else if (stepRise_s) begin
          state_s = STEP;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (run) begin
          if (div_r == DIV_LAST) begin
            advance_s = 1'b1;
            div_s     = {DIV_W{1'b0}};
          end else begin
            div_s = div_r + DIV_W'(1);
          end
        end else begin
          state_s = IDLE;
          div_s   = {DIV_W{1'b0}};
        end
      end
      STEP: begin
        advance_s = 1'b1;
        state_s   = IDLE;
      end
      default: begin
        state_s = IDLE;
        div_s   = {DIV_W{1'b0}};
      end
    endcase
  end

  // Grid, counters, flags and FSM registers: reset > load > advance > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      grid_r     <= '0;
      gen_r      <= {GEN_W{1'b0}};
      extinct_r  <= 1'b1;
      stable_r   <= 1'b0;
      stepPrev_r <= 1'b0;
      state_r    <= IDLE;
      div_r      <= {DIV_W{1'b0}};
    end else if (load) begin
      grid_r     <= userInput;
      gen_r      <= {GEN_W{1'b0}};
      extinct_r  <= (userInput == '0);
      stable_r   <= 1'b0;
      stepPrev_r <= step;
      state_r    <= IDLE;
      div_r      <= {DIV_W{1'b0}};
    end else begin
      stepPrev_r <= step;
      state_r    <= state_s;
      div_r      <= div_s;
      if (advance_s) begin
        grid_r    <= nextGrid_s;
        gen_r     <= gen_r + GEN_W'(1);
        extinct_r <= (nextGrid_s == '0);
        stable_r  <= (nextGrid_s == grid_r);
      end else begin
        grid_r    <= grid_r;
        gen_r     <= gen_r;
        extinct_r <= extinct_r;
        stable_r  <= stable_r;
      end
    end
  end

  assign cellStatus = grid_r;
  assign generation = gen_r;
  assign extinct    = extinct_r;
  assign stable     = stable_r;

endmodule
